systolic_pe_row: RTL
====================

Name: systolic_pe_row

Overview:
- Parametrised row of N weight-stationary integer MAC processing elements for the systolic array.
- The activation enters at the left edge and is registered through each PE. Each PE adds activation*weight to its own partial-sum input and registers the result, which drives that column's output.
- Weights are double-buffered. A shift chain loads the shadow weights, and a swap token travels with the activation wavefront, so in-flight data always completes with the weight it started under.

Parameters:
- N, 4, number of PEs (columns) in the row; N >= 1.
- DATA_W, 16, signed activation/weight width (two's complement).
- ACC_W, 40, signed partial-sum width; must satisfy ACC_W >= 2*DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_in  in  DATA_W  activation into PE0.
- a_valid_in  in  1  a_in is valid this cycle.
- psum_in  in  N*ACC_W  partial-sum inputs; column k is bits [k*ACC_W +: ACC_W]. The caller skews them: column k is presented k cycles after the matching a_in.
- w_data  in  DATA_W  weight word for the shadow chain.
- w_load  in  1  shift w_data into the shadow chain.
- w_swap  in  1  start a shadow-to-active swap wavefront.
- psum_out  out  N*ACC_W  registered partial-sum outputs, same packing as psum_in.
- psum_valid_out  out  N  per-column valid for psum_out.
- a_out  out  DATA_W  activation leaving PE N-1, for cascading to the next row or column.
- a_valid_out  out  1  a_out is valid.
- swap_busy  out  1  a swap token is in flight.
- load_err  out  1  sticky flag: a w_load arrived while swap_busy was high.

Behaviour:
- Reset: every register clears to 0 on the edge where rst=1. This covers psum_out, psum_valid_out, a_out, a_valid_out, swap_busy, load_err, the active and shadow weights, and the swap token pipe. rst overrides all other inputs; a mid-stream reset discards in-flight data and tokens.
- Activation pipe: a_pipe[0] <= a_in and v_pipe[0] <= a_valid_in. For k>0, a_pipe[k] <= a_pipe[k-1] and v_pipe[k] <= v_pipe[k-1]. Zeros are allowed to propagate.
- a_out = a_pipe[N-1] and a_valid_out = v_pipe[N-1]. Latency from a_in to a_out is N cycles.
- PE k operand: src_k is a_in for k=0, otherwise a_pipe[k-1]. The operand is valid when its matching valid bit is 1.
- PE k MAC, when its operand is valid: psum_out[k] <= psum_in[k] + sext(src_k * w_act[k]). The product is 2*DATA_W bits signed and sign-extended to ACC_W; the sum wraps modulo 2^ACC_W.
- psum_valid_out[k] <= operand valid. When the operand is invalid, psum_out[k] holds its value.
- Latency: psum_out[k] appears 1 cycle after psum_in[k] is sampled, which is k+1 cycles after a_in.
- Shadow chain: on w_load (when accepted), shadow[0] <= w_data and shadow[k] <= shadow[k-1]. After N loads, the first word loaded is in shadow[N-1].
- Swap wavefront: when w_swap is sampled at edge t, w_act[0] <= shadow[0] at edge t and tok[0] <= 1. Then tok[k] <= tok[k-1], and PE k (k>0) loads w_act[k] <= shadow[k] on the edge where tok[k-1]=1, i.e. edge t+k.
- Swap timing: products computed on a swap edge use the pre-swap weight. Activations issued at cycle <= t use old weights in every PE; activations issued at cycle >= t+1 use new weights.
- swap_busy is the OR of tok[0..N-2]. It is 1 for cycles t+1 .. t+N-1 and stays 0 when N=1.
- w_load while swap_busy=1: the load is ignored, the shadow is unchanged, and load_err is set to 1. load_err clears only on reset.
- w_load and w_swap in the same cycle with swap_busy=0: the swap captures the pre-shift shadow values for PE0, then the shift happens. This corrupts the shadow values seen by PEs 1..N-1, so it is defined as a caller error and also sets load_err.
- w_swap while swap_busy=1: a second token is launched and follows one or more cycles behind; each PE swaps again. This is legal.

Optional Feature:
- Macro: SYSTOLIC_PE_ROW_SAT_EN.
- Defined: each MAC add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow.
- Undefined: each MAC add wraps modulo 2^ACC_W.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles while driving random inputs -> all outputs 0, swap_busy=0, load_err=0.
- Load and compute (N=4, DATA_W=16, ACC_W=40):
  - Stimulus: w_load words 4,3,2,1 (shadow[0]=1, shadow[3]=4); w_swap; wait 4 cycles; a_in=5 valid at cycle t; psum_in all 0.
  - Response: psum_out[0]=5 after edge t, [1]=10 after t+1, [2]=15 after t+2, [3]=20 after t+3. a_out=5 with a_valid_out=1 after edge t+3.
- Signed: all weights -2, a_in=-3, each psum_in[k]=100 -> every psum_out[k]=106 with psum_valid_out[k] pulsing once.
- Swap mid-stream:
  - Stimulus: active weights 1 and shadow weights 2; a_in=1 valid every cycle; w_swap at cycle t.
  - Response: activations from cycles <= t give psum=1 in every column; from cycles >= t+1 give 2. swap_busy=1 for cycles t+1..t+3.
- Load during busy: w_load with w_data=7 at cycle t+1 after a swap at t -> shadow unchanged, load_err=1 and remains 1 until rst.
- Overflow: psum_in[0]=2^39-1, a_in=1, w0=1 -> psum_out[0]=-2^39 without the macro; 2^39-1 with SYSTOLIC_PE_ROW_SAT_EN.

Source files
------------

// File: rtl/systolic_pe_row.sv
// Row of N weight-stationary signed MAC PEs with double-buffered weights and a swap token wavefront.
// Optional build macro SYSTOLIC_PE_ROW_SAT_EN: saturating MAC adds instead of wrapping adds.
module systolic_pe_row #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     a_in,
    input  logic                  a_valid_in,
    input  logic [N*ACC_W-1:0]    psum_in,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  w_load,
    input  logic                  w_swap,
    output logic [N*ACC_W-1:0]    psum_out,
    output logic [N-1:0]          psum_valid_out,
    output logic [DATA_W-1:0]     a_out,
    output logic                  a_valid_out,
    output logic                  swap_busy,
    output logic                  load_err
);

    localparam int TOK_W = (N > 1) ? N - 1 : 1;

    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    data_t            a_pipe_q [N];
    logic [N-1:0]     v_pipe_q;
    data_t            shadow_q [N];
    data_t            w_act_q  [N];
    acc_t             psum_q   [N];
    logic [N-1:0]     psum_vld_q;
    logic [TOK_W-1:0] tok_q;
    logic             load_err_q;
    logic             load_err_d;
    logic             load_ok;

    data_t        src   [N];
    logic [N-1:0] src_vld;

    function automatic acc_t mac_add(input acc_t psum, input data_t a, input data_t w);
        prod_t prod;
        acc_t  ext;
`ifdef SYSTOLIC_PE_ROW_SAT_EN
        logic signed [ACC_W:0] sum;
`endif
        prod = a * w;
        ext  = ACC_W'(prod);
`ifdef SYSTOLIC_PE_ROW_SAT_EN
        sum = {psum[ACC_W-1], psum} + {ext[ACC_W-1], ext};
        // Top two bits disagree only on signed overflow; the carry-out bit gives the true sign.
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
`else
        return psum + ext;
`endif
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            src[k]     = (k == 0) ? data_t'(a_in) : a_pipe_q[(k == 0) ? 0 : k-1];
            src_vld[k] = (k == 0) ? a_valid_in   : v_pipe_q[(k == 0) ? 0 : k-1];
        end
    end

    assign swap_busy  = (N > 1) ? |tok_q : 1'b0;
    assign load_ok    = w_load && !swap_busy;
    // Load during a wavefront, or load coincident with swap, corrupts what downstream PEs see.
    assign load_err_d = load_err_q | (w_load & (swap_busy | w_swap));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                a_pipe_q[k] <= '0;
                shadow_q[k] <= '0;
                w_act_q[k]  <= '0;
                psum_q[k]   <= '0;
            end
            v_pipe_q   <= '0;
            psum_vld_q <= '0;
            tok_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            a_pipe_q[0] <= a_in;
            v_pipe_q[0] <= a_valid_in;
            for (int k = 1; k < N; k++) begin
                a_pipe_q[k] <= a_pipe_q[k-1];
                v_pipe_q[k] <= v_pipe_q[k-1];
            end

            for (int k = 0; k < N; k++) begin
                if (src_vld[k])
                    psum_q[k] <= mac_add(acc_t'(psum_in[k*ACC_W +: ACC_W]), src[k], w_act_q[k]);
                psum_vld_q[k] <= src_vld[k];
            end

            if (load_ok) begin
                shadow_q[0] <= w_data;
                for (int k = 1; k < N; k++)
                    shadow_q[k] <= shadow_q[k-1];
            end

            if (w_swap)
                w_act_q[0] <= shadow_q[0];
            for (int k = 1; k < N; k++)
                if (tok_q[k-1])
                    w_act_q[k] <= shadow_q[k];

            tok_q[0] <= (N > 1) ? w_swap : 1'b0;
            for (int k = 1; k < TOK_W; k++)
                tok_q[k] <= tok_q[k-1];

            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++)
            psum_out[k*ACC_W +: ACC_W] = psum_q[k];
    end

    assign psum_valid_out = psum_vld_q;
    assign a_out          = a_pipe_q[N-1];
    assign a_valid_out    = v_pipe_q[N-1];
    assign load_err       = load_err_q;

endmodule
